// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main controller: opcodes, state
// encoding, datapath select codes and the control word passed to the decoder.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALURES = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  typedef struct packed {
    logic       irwrite;
    logic       pcwrite;
    logic       memwrite;
    logic       regwrite;
    logic       branch;
    logic [1:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
  } ctrl_word_t;

  function automatic logic is_supported(input logic [5:0] op);
    logic ok;
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_ctrl_word_decoder.sv
// Combinational map from controller state to the full datapath control word.
module mc_ctrl_word_decoder
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  output ctrl_word_t cw
);

  // Moore output table; unreachable codes fall back to an all-idle word
  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.irwrite = 1'b1;
        cw.pcwrite = 1'b1;
        cw.alusrcb = SRCB_FOUR;
        cw.aluop   = ALU_ADD;
      end
      S_DECODE: begin
        cw.alusrcb = SRCB_IMMSH2;
        cw.aluop   = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_IMM;
        cw.aluop   = ALU_ADD;
      end
      S_MEMREAD: cw.iord = 1'b1;
      S_MEMWB: begin
        cw.regwrite = 1'b1;
        cw.memtoreg = 1'b1;
      end
      S_MEMWRITE: begin
        cw.iord     = 1'b1;
        cw.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_REGB;
        cw.aluop   = ALU_FUNCT;
      end
      S_ALUWB: begin
        cw.regwrite = 1'b1;
        cw.regdst   = 1'b1;
      end
      S_ADDIWB: cw.regwrite = 1'b1;
      S_BRANCH: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_REGB;
        cw.aluop   = ALU_SUB;
        cw.pcsrc   = PCSRC_ALUOUT;
        cw.branch  = 1'b1;
      end
      S_JUMP: begin
        cw.pcwrite = 1'b1;
        cw.pcsrc   = PCSRC_JUMP;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_main_controller.sv
// Multicycle MIPS main controller: state register, next-state sequencing,
// reset gating of write enables, PCEn and illegal-opcode detection.
module multicycle_main_controller
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       PCWrite,
  output logic       PCEn,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t     state_r;
  state_t     state_next_s;
  state_t     dec_state_s;
  ctrl_word_t cw_s;

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state sequencing; opcode is re-read in MEMADR since IR holds still
  always_comb begin
    state_next_s = S_FETCH;
    case (state_r)
      S_FETCH:  state_next_s = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next_s = S_MEMADR;
          OP_RTYPE:     state_next_s = S_EXECUTE;
          OP_BEQ:       state_next_s = S_BRANCH;
          OP_ADDI:      state_next_s = S_ADDIEX;
          OP_J:         state_next_s = S_JUMP;
          default:      state_next_s = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW) begin
          state_next_s = S_MEMREAD;
        end else begin
          state_next_s = S_MEMWRITE;
        end
      end
      S_MEMREAD: state_next_s = S_MEMWB;
      S_EXECUTE: state_next_s = S_ALUWB;
      S_ADDIEX:  state_next_s = S_ADDIWB;
      default:   state_next_s = S_FETCH;
    endcase
  end

  // During reset the selects show FETCH values while every enable is held low
  assign dec_state_s = rst ? S_FETCH : state_r;

  mc_ctrl_word_decoder u_decoder (
    .state (dec_state_s),
    .cw    (cw_s)
  );

  assign ALUOp      = cw_s.aluop;
  assign ALUSrcA    = cw_s.alusrca;
  assign ALUSrcB    = cw_s.alusrcb;
  assign PCSrc      = cw_s.pcsrc;
  assign IorD       = cw_s.iord;
  assign RegDst     = cw_s.regdst;
  assign MemtoReg   = cw_s.memtoreg;
  assign IRWrite    = cw_s.irwrite  & ~rst;
  assign MemWrite   = cw_s.memwrite & ~rst;
  assign RegWrite   = cw_s.regwrite & ~rst;
  assign PCWrite    = cw_s.pcwrite  & ~rst;
  assign PCEn       = ~rst & (cw_s.pcwrite | (cw_s.branch & zero));
  assign illegal_op = ~rst & (state_r == S_DECODE) & ~is_supported(opcode);
  assign state      = state_r;

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Self-checking bench: directed scenarios plus randomized instruction streams
// checked against a per-instruction, per-step behavioural model.
module tb_multicycle_main_controller;

  logic       clk;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic [1:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic       IorD;
  logic       RegDst;
  logic       MemtoReg;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       PCWrite;
  logic       PCEn;
  logic       illegal_op;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;

  multicycle_main_controller dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .ALUOp      (ALUOp),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .PCSrc      (PCSrc),
    .IorD       (IorD),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .IRWrite    (IRWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .PCWrite    (PCWrite),
    .PCEn       (PCEn),
    .illegal_op (illegal_op),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction kinds: 0 lw, 1 sw, 2 R-type, 3 beq, 4 addi, 5 j, 6 illegal
  int seq_tbl [7][5] = '{'{0, 1, 2, 3, 4}, '{0, 1, 2, 5, 0}, '{0, 1, 6, 7, 0},
                         '{0, 1, 8, 0, 0}, '{0, 1, 9, 10, 0}, '{0, 1, 11, 0, 0},
                         '{0, 1, 0, 0, 0}};
  int len_tbl [7] = '{5, 4, 4, 3, 4, 3, 2};

  logic [19:0] act;
  assign act = {state, IRWrite, PCWrite, MemWrite, RegWrite, PCEn, illegal_op,
                ALUOp, ALUSrcA, ALUSrcB, PCSrc, IorD, RegDst, MemtoReg};

  function automatic logic [5:0] op_of(input int kind);
    logic [5:0] op;
    case (kind)
      0: op = 6'b100011;
      1: op = 6'b101011;
      2: op = 6'b000000;
      3: op = 6'b000100;
      4: op = 6'b001000;
      5: op = 6'b000010;
      default: begin
        op = 6'b111111;
        do op = 6'($urandom_range(0, 63));
        while (op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010});
      end
    endcase
    return op;
  endfunction

  // What the datapath must see at step k of an instruction of the given kind
  function automatic logic [19:0] model(input int kind, input int k, input logic z);
    logic ir, pcw, mw, rw, pcen, ill, srca, iord, rdst, m2r;
    logic [1:0] aop, srcb, pcsrc;
    logic [3:0] st;
    {ir, pcw, mw, rw, pcen, ill, srca, iord, rdst, m2r} = 10'b0;
    {aop, srcb, pcsrc} = 6'b0;
    st = 4'(seq_tbl[kind][k]);
    if (k == 0) begin
      ir = 1'b1; pcw = 1'b1; pcen = 1'b1; srcb = 2'b01;
    end else if (k == 1) begin
      srcb = 2'b11; ill = (kind == 6);
    end else begin
      case (kind)
        0: begin
          if (k == 2) begin srca = 1'b1; srcb = 2'b10; end
          else if (k == 3) iord = 1'b1;
          else begin rw = 1'b1; m2r = 1'b1; end
        end
        1: begin
          if (k == 2) begin srca = 1'b1; srcb = 2'b10; end
          else begin iord = 1'b1; mw = 1'b1; end
        end
        2: begin
          if (k == 2) begin srca = 1'b1; aop = 2'b10; end
          else begin rw = 1'b1; rdst = 1'b1; end
        end
        3: begin srca = 1'b1; aop = 2'b01; pcsrc = 2'b01; pcen = z; end
        4: begin
          if (k == 2) begin srca = 1'b1; srcb = 2'b10; end
          else rw = 1'b1;
        end
        default: begin pcw = 1'b1; pcsrc = 2'b10; pcen = 1'b1; end
      endcase
    end
    return {st, ir, pcw, mw, rw, pcen, ill, aop, srca, srcb, pcsrc, iord, rdst, m2r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; opcode = 6'b000000; zero = 1'b1;
    tick(); tick();
    checks++;
    if (state !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++;
    if ({IRWrite, PCWrite, MemWrite, RegWrite, PCEn, illegal_op} !== 6'b0) begin
      failures++;
      $display("FAIL reset_enables got=%b exp=000000",
               {IRWrite, PCWrite, MemWrite, RegWrite, PCEn, illegal_op});
    end
    checks++;
    if ({ALUSrcB, ALUOp, ALUSrcA, PCSrc, IorD, RegDst, MemtoReg} !== 10'b0100000000) begin
      failures++;
      $display("FAIL reset_selects got=%b exp=0100000000",
               {ALUSrcB, ALUOp, ALUSrcA, PCSrc, IorD, RegDst, MemtoReg});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({IRWrite, PCWrite} !== 2'b11) begin
      failures++; $display("FAIL reset_release_fetch got=%b exp=11", {IRWrite, PCWrite});
    end
  endtask

  task automatic test_lw();
    int exp_st [5] = '{0, 1, 2, 3, 4};
    opcode = 6'b100011; zero = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if ({state, RegWrite, MemtoReg, IorD} !== {4'(exp_st[k]), (k == 4), (k == 4), (k == 3)}) begin
        failures++;
        $display("FAIL lw_step%0d got st=%0d rw=%b m2r=%b iord=%b exp st=%0d", k, state,
                 RegWrite, MemtoReg, IorD, exp_st[k]);
      end
      tick();
    end
    checks++;
    if (state !== 4'd0) begin failures++; $display("FAIL lw_return got=%0d exp=0", state); end
  endtask

  task automatic test_beq();
    opcode = 6'b000100; zero = 1'b0;
    tick(); tick();
    zero = 1'b1; #1;
    checks++;
    if ({state, PCEn, ALUOp, PCSrc} !== {4'd8, 1'b1, 2'b01, 2'b01}) begin
      failures++;
      $display("FAIL beq_taken got st=%0d pcen=%b aluop=%b pcsrc=%b exp st=8 pcen=1 aluop=01 pcsrc=01",
               state, PCEn, ALUOp, PCSrc);
    end
    zero = 1'b0; #1;
    checks++;
    if (PCEn !== 1'b0) begin failures++; $display("FAIL beq_not_taken pcen got=%b exp=0", PCEn); end
    tick();
    checks++;
    if (state !== 4'd0) begin failures++; $display("FAIL beq_return got=%0d exp=0", state); end
  endtask

  task automatic test_illegal();
    opcode = 6'b111111; zero = 1'b0;
    tick(); #1;
    checks++;
    if ({state, illegal_op, RegWrite, MemWrite} !== {4'd1, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL illegal_decode got st=%0d ill=%b rw=%b mw=%b exp st=1 ill=1 rw=0 mw=0",
               state, illegal_op, RegWrite, MemWrite);
    end
    tick();
    checks++;
    if ({state, illegal_op} !== {4'd0, 1'b0}) begin
      failures++; $display("FAIL illegal_return got st=%0d ill=%b exp st=0 ill=0", state, illegal_op);
    end
  endtask

  task automatic test_reset_mid();
    opcode = 6'b100011; zero = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (state !== 4'd3) begin failures++; $display("FAIL mid_reach_memread got=%0d exp=3", state); end
    rst = 1'b1; #1;
    checks++;
    if ({IRWrite, PCWrite, MemWrite, RegWrite, PCEn} !== 5'b0) begin
      failures++;
      $display("FAIL mid_reset_enables got=%b exp=00000", {IRWrite, PCWrite, MemWrite, RegWrite, PCEn});
    end
    tick();
    checks++;
    if (state !== 4'd0) begin failures++; $display("FAIL mid_reset_state got=%0d exp=0", state); end
    rst = 1'b0; #1;
    checks++;
    if ({IRWrite, PCWrite} !== 2'b11) begin
      failures++; $display("FAIL mid_release_fetch got=%b exp=11", {IRWrite, PCWrite});
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      int kind;
      kind = int'($urandom_range(0, 6));
      opcode = op_of(kind);
      for (int k = 0; k < len_tbl[kind]; k++) begin
        logic [19:0] exp_v;
        zero = 1'($urandom_range(0, 1));
        #1;
        exp_v = model(kind, k, zero);
        checks++;
        if (act !== exp_v) begin
          failures++;
          $display("FAIL random_n%0d_kind%0d_step%0d op=%b got=%b exp=%b", n, kind, k, opcode, act, exp_v);
        end
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_beq();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
